// File: rtl/nibble_serial_pkg.sv
// rtl/nibble_serial_pkg.sv - shared types and helpers for the nibble-serial adder
// Contents: FSM state encoding, nibble width constant, index-width helper.
package nibble_serial_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index counter; never narrower than one bit so the
  // WIDTH=4 build still has a legal register.
  function automatic int idx_width(input int width);
    int nnib;
    nnib = width / NIB_W;
    return (nnib <= 1) ? 1 : $clog2(nnib);
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - combinational 4-bit ripple-carry adder slice
// Ports:
//   a, b  in  4  addend nibbles
//   cin   in  1  carry in
//   sum   out 4  nibble sum
//   cout  out 1  carry out of bit 3
module nibble_add4
  import nibble_serial_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - adds two WIDTH-bit operands one nibble per clock
// Optional feature macro: NIBBLE_SERIAL_SUB_EN (adds the sub input for a - b).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start_valid/ready      operand handshake; a, b, c_in (and sub) sampled on it
//   sum, c_out, ovf        registered result, final carry, signed overflow
//   done_valid/ready       result handshake
//   busy                   high while adding or holding a result
module nibble_serial_adder_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int NNIB = WIDTH / NIB_W;
  localparam int IW   = idx_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, c_out_q, ovf_q;
  logic [IW-1:0]    idx_q;

  logic             accept, last;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic [IW+1:0]    nib_lsb;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Subtraction as a + ~b + 1; the stored B is already inverted so the
  // overflow rule below needs no special case.
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | c_in;
`else
  assign b_in   = b;
  assign cin_in = c_in;
`endif

  assign accept  = start_valid && start_ready;
  assign last    = (idx_q == IW'(NNIB - 1));
  assign nib_lsb = {idx_q, 2'b00};

  nibble_add4 u_slice (
    .a    (a_q[nib_lsb +: NIB_W]),
    .b    (b_q[nib_lsb +: NIB_W]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_in;
      carry_q <= cin_in;
      sum_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == ADD) begin
      sum_q[nib_lsb +: NIB_W] <= slice_sum;
      carry_q                 <= slice_cout;
      if (last) begin
        idx_q   <= '0;
        c_out_q <= slice_cout;
        // slice_sum[3] is the new result MSB on the final nibble.
        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[NIB_W-1] != a_q[WIDTH-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
